// File: rtl/droop_pkg.sv
// Shared types and helpers for both ends of the brake interface.
package droop_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRIP     = 2'd2,
        COOLDOWN = 2'd3
    } droop_det_state_t;

    // Brake state as seen by the PLL droop manager.
    typedef enum logic [1:0] {
        BRAKES_OFF     = 2'd0,
        BRAKES_ON      = 2'd1,
        BRAKES_RELEASE = 2'd2
    } brake_state_t;

    localparam int unsigned DEF_VMON_W           = 10;
    localparam int unsigned DEF_DEBOUNCE         = 2;
    localparam int unsigned DEF_RELEASE_CYCLES   = 4;
    localparam int unsigned DEF_MIN_BRAKE_CYCLES = 16;
    localparam int unsigned DEF_LOCKOUT_CYCLES   = 64;
    localparam int unsigned DEF_CNT_W            = 16;

    // Increment that sticks at the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/droop_if.sv
// Monitor inputs, brake handshake and telemetry between the detector and its consumers.
interface droop_if
    import droop_pkg::*;
#(
    parameter int unsigned VMON_W = DEF_VMON_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);
    logic                   enable;
    logic [VMON_W-1:0]      vmon_code;
    logic                   vmon_valid;
    logic [VMON_W-1:0]      thr_assert;
    logic [VMON_W-1:0]      thr_release;
    logic                   mgr_idle;
    logic                   brake;
    droop_det_state_t       det_state;
    logic [CNT_W-1:0]       event_count;
    logic [CNT_W-1:0]       retrig_count;
    logic [VMON_W-1:0]      min_code;

    modport master (
        input  enable, vmon_code, vmon_valid, thr_assert, thr_release, mgr_idle,
        output brake, det_state, event_count, retrig_count, min_code
    );

    modport slave (
        output enable, vmon_code, vmon_valid, thr_assert, thr_release, mgr_idle,
        input  brake, det_state, event_count, retrig_count, min_code
    );

endinterface

// File: rtl/droop_detector_consec.sv
// Consecutive-sample counter: invalid cycles hold, a failing valid sample clears.
module consec_counter #(
    parameter int unsigned TARGET = 2
) (
    input  logic refclk,
    input  logic resetn,
    input  logic clr_i,
    input  logic valid_i,
    input  logic hit_i,
    output logic reached_o
);
    localparam int unsigned W = $clog2(TARGET + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (valid_i) begin
            if (!hit_i)
                cnt_d = '0;
            else if (cnt_q < W'(TARGET))
                cnt_d = cnt_q + 1'b1;
        end
    end

    // Reached includes the sample presented this cycle.
    assign reached_o = (cnt_d == W'(TARGET));

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/droop_detector.sv
// Supply-droop detector: debounced trip, hysteretic hold, manager-gated re-arm.
module droop_detector
    import droop_pkg::*;
#(
    parameter int unsigned VMON_W           = DEF_VMON_W,
    parameter int unsigned DEBOUNCE         = DEF_DEBOUNCE,
    parameter int unsigned RELEASE_CYCLES   = DEF_RELEASE_CYCLES,
    parameter int unsigned MIN_BRAKE_CYCLES = DEF_MIN_BRAKE_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES   = DEF_LOCKOUT_CYCLES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  logic     refclk,
    input  logic     resetn,
    droop_if.master  bus
);
    localparam int unsigned HOLD_W = $clog2(MIN_BRAKE_CYCLES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    droop_det_state_t    state_q, state_d;
    logic                brake_q, brake_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [CNT_W-1:0]    event_q, event_d;
    logic [CNT_W-1:0]    retrig_q, retrig_d;
    logic [VMON_W-1:0]   min_q, min_d;

    logic [VMON_W-1:0]   thr_rel_eff;
    logic                below, above;
    logic                ast_reached, rel_reached;

    // Release never sits below assert, so a bad config cannot chatter.
    assign thr_rel_eff = (bus.thr_release > bus.thr_assert) ? bus.thr_release : bus.thr_assert;
    assign below = bus.vmon_valid && (bus.vmon_code < bus.thr_assert);
    assign above = bus.vmon_valid && (bus.vmon_code >= thr_rel_eff);

    consec_counter #(.TARGET(DEBOUNCE)) u_assert_cnt (
        .refclk    (refclk),
        .resetn    (resetn),
        .clr_i     ((state_q == DISARMED) || (state_q == TRIP)),
        .valid_i   (bus.vmon_valid),
        .hit_i     (below),
        .reached_o (ast_reached)
    );

    consec_counter #(.TARGET(RELEASE_CYCLES)) u_release_cnt (
        .refclk    (refclk),
        .resetn    (resetn),
        .clr_i     (state_q != TRIP),
        .valid_i   (bus.vmon_valid),
        .hit_i     (above),
        .reached_o (rel_reached)
    );

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) state_q <= DISARMED;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = DISARMED;
        end else begin
            unique case (state_q)
                DISARMED: state_d = ARMED;
                ARMED:    if (ast_reached) state_d = TRIP;
                TRIP:     if (hold_q == '0 && rel_reached) state_d = COOLDOWN;
                COOLDOWN: begin
                    if (ast_reached)                         state_d = TRIP;
                    else if (lock_q == '0 && bus.mgr_idle)   state_d = ARMED;
                end
                default:  state_d = DISARMED;
            endcase
        end
    end

    always_comb begin
        brake_d  = (state_d == TRIP);
        hold_d   = hold_q;
        lock_d   = lock_q;
        event_d  = event_q;
        retrig_d = retrig_q;
        min_d    = min_q;

        // Timers preload while outside their state so entry sees the full count.
        if (state_q != TRIP)      hold_d = HOLD_W'(MIN_BRAKE_CYCLES - 1);
        else if (hold_q != '0)    hold_d = hold_q - 1'b1;
        if (state_q != COOLDOWN)  lock_d = LOCK_W'(LOCKOUT_CYCLES - 1);
        else if (lock_q != '0)    lock_d = lock_q - 1'b1;

        if (state_q == ARMED && state_d == TRIP)
            event_d = CNT_W'(sat_inc(32'(event_q), CNT_W));
        if (state_q == COOLDOWN && state_d == TRIP)
            retrig_d = CNT_W'(sat_inc(32'(retrig_q), CNT_W));

        if (state_q != TRIP && state_d == TRIP)
            min_d = bus.vmon_code;
        else if (state_q == TRIP && bus.vmon_valid && bus.vmon_code < min_q)
            min_d = bus.vmon_code;
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            brake_q  <= 1'b0;
            hold_q   <= '0;
            lock_q   <= '0;
            event_q  <= '0;
            retrig_q <= '0;
            min_q    <= '1;
        end else begin
            brake_q  <= brake_d;
            hold_q   <= hold_d;
            lock_q   <= lock_d;
            event_q  <= event_d;
            retrig_q <= retrig_d;
            min_q    <= min_d;
        end
    end

    assign bus.brake        = brake_q;
    assign bus.det_state    = state_q;
    assign bus.event_count  = event_q;
    assign bus.retrig_count = retrig_q;
    assign bus.min_code     = min_q;

endmodule
